// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code reader path.
// FSM encodings and the supported word width.
package gray_pkg;

    localparam int GRAY_W = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] DECODE  = 2'd2;
    localparam logic [1:0] PRESENT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_SETTLE  = SETTLE,
        S_DECODE  = DECODE,
        S_PRESENT = PRESENT
    } state_t;

endpackage

// File: rtl/decodificador_gray.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of all Gray bits at or above it.
module decodificador_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/control_lectura_gray.sv
// Gray switch reader: synchronize, debounce, decode, check step legality,
// and hand the result downstream over valid/ready.
module control_lectura_gray
    import gray_pkg::*;
#(
    parameter int WIDTH         = GRAY_W,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             enable,
    input  logic             ready_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             valid_out,
    output logic             step_err,
    output logic             busy
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] last_acc_q, last_acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             step_err_q, step_err_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] dec_bin;

    decodificador_gray #(
        .WIDTH(WIDTH)
    ) u_dec (
        .gray(cand_q),
        .bin (dec_bin)
    );

    function automatic int unsigned popcnt(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        sync1_d    = gray_in;
        sync_d     = sync1_q;
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        last_acc_d = last_acc_q;
        bin_d      = bin_q;
        step_err_d = step_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable && (sync_q != last_acc_q)) begin
                    state_d = S_SETTLE;
                    cand_d  = sync_q;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (sync_q != cand_q) begin
                    // Bounce: restart the stability window on the new code
                    cand_d = sync_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                bin_d      = dec_bin;
                step_err_d = (popcnt(cand_q ^ last_acc_q) != 1);
                last_acc_d = cand_q;
                state_d    = S_PRESENT;
            end
            S_PRESENT: begin
                if (ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags track the next state so they line up with it
        valid_d = (state_d == S_PRESENT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= '0;
            sync_q     <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            last_acc_q <= '0;
            bin_q      <= '0;
            step_err_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync_q     <= sync_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            last_acc_q <= last_acc_d;
            bin_q      <= bin_d;
            step_err_q <= step_err_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bin_out   = bin_q;
    assign step_err  = step_err_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_control_lectura_gray.sv
// Directed bench for the Gray reader controller, STABLE_CYCLES=4.
// Expected values are hand-computed from the Gray decode and step rules.
module tb_control_lectura_gray;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic       enable;
    logic       ready_in;
    logic [3:0] bin_out;
    logic       valid_out;
    logic       step_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    control_lectura_gray #(
        .WIDTH(4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .enable   (enable),
        .ready_in (ready_in),
        .bin_out  (bin_out),
        .valid_out(valid_out),
        .step_err (step_err),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (valid_out !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(valid_out), 32'd1);
    endtask

    initial begin
        int e0;
        int pulses;
        int first_edge;
        logic prev_v;

        rst      = 1'b1;
        gray_in  = 4'b0000;
        enable   = 1'b1;
        ready_in = 1'b1;

        // Reset
        tick(2);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_err", 32'(step_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (valid_out !== 1'b0) pulses++;
        end
        chk("idle_no_valid", 32'(pulses), 32'd0);

        // Single step 0000 -> 0001
        e0 = edge_cnt;
        gray_in = 4'b0001;
        tick(2);
        chk("step_busy_e2", 32'(busy), 32'd0);
        tick(1);
        chk("step_busy_e3", 32'(busy), 32'd1);
        tick(4);
        chk("step_valid_e7", 32'(valid_out), 32'd0);
        tick(1);
        chk("step_edge", 32'(edge_cnt - e0), 32'd8);
        chk("step_valid_e8", 32'(valid_out), 32'd1);
        chk("step_bin", 32'(bin_out), 32'h1);
        chk("step_err", 32'(step_err), 32'd0);
        tick(1);
        chk("step_valid_e9", 32'(valid_out), 32'd0);
        chk("step_bin_held", 32'(bin_out), 32'h1);

        // Legal step to 0011, then illegal jump to 1000
        gray_in = 4'b0011;
        wait_valid("leg_wait", 20);
        chk("leg_bin", 32'(bin_out), 32'h2);
        chk("leg_err", 32'(step_err), 32'd0);
        tick(1);
        gray_in = 4'b1000;
        wait_valid("ill_wait", 20);
        chk("ill_bin", 32'(bin_out), 32'hF);
        chk("ill_err", 32'(step_err), 32'd1);
        tick(1);

        // Bounce 0110/0111, settling on 0111
        e0 = 0;
        for (int k = 0; k < 6; k++) begin
            gray_in = (k % 2 == 1) ? 4'b0111 : 4'b0110;
            if (k == 5) e0 = edge_cnt;
            tick(2);
            chk("bnc_quiet", 32'(valid_out), 32'd0);
        end
        pulses = 0;
        first_edge = 0;
        prev_v = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (valid_out === 1'b1 && !prev_v) begin
                pulses++;
                if (first_edge == 0) first_edge = edge_cnt;
            end
            prev_v = valid_out;
            tick(1);
        end
        chk("bnc_pulses", 32'(pulses), 32'd1);
        chk("bnc_edge", 32'(first_edge - e0), 32'd8);
        chk("bnc_bin", 32'(bin_out), 32'h5);
        chk("bnc_err", 32'(step_err), 32'd1);

        // Backpressure while presenting 1100
        ready_in = 1'b0;
        gray_in  = 4'b1100;
        wait_valid("bp_wait", 20);
        chk("bp_bin", 32'(bin_out), 32'h8);
        chk("bp_err", 32'(step_err), 32'd1);
        gray_in = 4'b1101;
        tick(10);
        chk("bp_valid_hold", 32'(valid_out), 32'd1);
        chk("bp_bin_hold", 32'(bin_out), 32'h8);
        ready_in = 1'b1;
        tick(1);
        chk("bp_xfer", 32'(valid_out), 32'd0);
        e0 = edge_cnt;
        wait_valid("bp_next_wait", 20);
        chk("bp_gap", 32'(edge_cnt - e0), 32'd6);
        chk("bp_next_bin", 32'(bin_out), 32'h9);
        chk("bp_next_err", 32'(step_err), 32'd0);
        tick(1);

        // Abort from SETTLE via enable
        gray_in = 4'b1111;
        tick(4);
        chk("ab_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        tick(1);
        chk("ab_idle", 32'(busy), 32'd0);
        gray_in = 4'b1101;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (valid_out !== 1'b0 || busy !== 1'b0) pulses++;
        end
        chk("ab_quiet", 32'(pulses), 32'd0);
        enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (valid_out !== 1'b0) pulses++;
        end
        chk("ab_no_repeat", 32'(pulses), 32'd0);

        // Reset while presenting
        ready_in = 1'b0;
        gray_in  = 4'b1111;
        wait_valid("rp_wait", 20);
        chk("rp_bin", 32'(bin_out), 32'hA);
        chk("rp_err", 32'(step_err), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("rp_valid", 32'(valid_out), 32'd0);
        chk("rp_busy", 32'(busy), 32'd0);
        chk("rp_bin0", 32'(bin_out), 32'd0);
        chk("rp_err0", 32'(step_err), 32'd0);
        rst = 1'b0;
        e0 = edge_cnt;
        wait_valid("rp_again_wait", 20);
        chk("rp_again_edge", 32'(edge_cnt - e0), 32'd8);
        chk("rp_again_bin", 32'(bin_out), 32'hA);
        chk("rp_again_err", 32'(step_err), 32'd1);
        ready_in = 1'b1;
        tick(1);
        chk("rp_done", 32'(valid_out), 32'd0);
        chk("rp_bin_kept", 32'(bin_out), 32'hA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
